// File: rtl/mem_arbiter_pkg.sv
// Shared widths, access-size and FSM encodings, and the misalignment rule for the
// instruction/data RAM arbiter.
package mem_arbiter_pkg;

    localparam int API_ADDR_WIDTH = 32;
    localparam int API_DATA_WIDTH = 32;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE  = 2'b00,
        MEM_ARB_ISSUE = 2'b01,
        MEM_ARB_RESP  = 2'b10
    } mem_arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } mem_arb_owner_e;

    // Reserved size and any access not naturally aligned to its size is an error.
    function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_W: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (fetch + load/store) and RAM-side signals of the arbiter; the arbiter
// uses the slave modport, the core/RAM environment the master modport.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                      if_req;
    logic [API_ADDR_WIDTH-1:0] if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [API_DATA_WIDTH-1:0] if_rdata;

    logic                      d_req;
    logic                      d_we;
    logic [1:0]                d_size;
    logic                      d_unsigned;
    logic [API_ADDR_WIDTH-1:0] d_addr;
    logic [API_DATA_WIDTH-1:0] d_wdata;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [API_DATA_WIDTH-1:0] d_rdata;
    logic                      d_err;

    logic                      mem_en;
    logic [API_ADDR_WIDTH-1:0] mem_addr;
    logic [API_DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]                mem_wr_mask;
    logic [API_DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_en, mem_addr, mem_wdata, mem_wr_mask
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_en, mem_addr, mem_wdata, mem_wr_mask
    );

endinterface

// File: rtl/mem_arbiter_lane_fmt.sv
// Purely combinational byte-lane formatter: store mask/replication with misalign
// detection, and load lane extraction with sign or zero extension.
module mem_lane_fmt
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]                st_size,
    input  logic [1:0]                st_addr_lo,
    input  logic                      st_we,
    input  logic [API_DATA_WIDTH-1:0] st_wdata,
    output logic [3:0]                st_mask,
    output logic [API_DATA_WIDTH-1:0] st_lane_wdata,
    output logic                      st_err,
    input  logic [1:0]                ld_size,
    input  logic [1:0]                ld_addr_lo,
    input  logic                      ld_unsigned,
    input  logic [API_DATA_WIDTH-1:0] ld_rdata,
    output logic [API_DATA_WIDTH-1:0] ld_data
);

    logic [7:0]  lane_b_s;
    logic [15:0] lane_h_s;

    // Store path: erroneous accesses and loads never produce a write mask.
    always_comb begin
        st_err        = access_misaligned(st_size, st_addr_lo);
        st_mask       = 4'b0000;
        st_lane_wdata = {API_DATA_WIDTH{1'b0}};
        if (st_we && !st_err) begin
            case (st_size)
                MEM_SIZE_B: begin
                    st_mask       = 4'b0001 << st_addr_lo;
                    st_lane_wdata = {4{st_wdata[7:0]}};
                end
                MEM_SIZE_H: begin
                    st_mask       = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_lane_wdata = {2{st_wdata[15:0]}};
                end
                MEM_SIZE_W: begin
                    st_mask       = 4'b1111;
                    st_lane_wdata = st_wdata;
                end
                default: begin
                    st_mask       = 4'b0000;
                    st_lane_wdata = {API_DATA_WIDTH{1'b0}};
                end
            endcase
        end else begin
            st_mask       = 4'b0000;
            st_lane_wdata = {API_DATA_WIDTH{1'b0}};
        end
    end

    // Load path: pick the addressed lane, then extend to the full word.
    always_comb begin
        lane_b_s = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        lane_h_s = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data  = {API_DATA_WIDTH{1'b0}};
        case (ld_size)
            MEM_SIZE_B: ld_data = ld_unsigned ? {24'h00_0000, lane_b_s} : {{24{lane_b_s[7]}}, lane_b_s};
            MEM_SIZE_H: ld_data = ld_unsigned ? {16'h0000, lane_h_s} : {{16{lane_h_s[15]}}, lane_h_s};
            MEM_SIZE_W: ld_data = ld_rdata;
            default:    ld_data = {API_DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM between instruction fetch and load/store with a fixed
// two-cycle response. Define MEM_ARB_RR_EN for round-robin instead of data-first priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    mem_arb_state_e state_r;
    mem_arb_state_e state_next_s;
    mem_arb_owner_e owner_r;
    logic [1:0]     size_r;
    logic [1:0]     addr_lo_r;
    logic           we_r;
    logic           unsigned_r;
    logic           err_r;

    logic                      mem_en_r;
    logic [API_ADDR_WIDTH-1:0] mem_addr_r;
    logic [API_DATA_WIDTH-1:0] mem_wdata_r;
    logic [3:0]                mem_wr_mask_r;

    logic grant_ok_s, pick_data_s, gnt_d_s, gnt_i_s, any_gnt_s;
    logic if_rvalid_s, d_rvalid_s, d_err_s;
    logic [API_DATA_WIDTH-1:0] if_rdata_s, d_rdata_s;

    logic [API_ADDR_WIDTH-1:0] req_addr_s;
    logic [1:0]                st_size_s, st_addr_lo_s;
    logic                      st_we_s, st_err_s;
    logic [3:0]                st_mask_s;
    logic [API_DATA_WIDTH-1:0] st_lane_wdata_s, ld_data_s;

`ifdef MEM_ARB_RR_EN
    mem_arb_owner_e last_owner_r;

    // On a tie the port that did not win the previous grant goes first.
    always_comb begin
        if (bus.d_req && bus.if_req) begin
            pick_data_s = (last_owner_r == OWN_FETCH);
        end else begin
            pick_data_s = bus.d_req;
        end
    end

    // Remember which port was granted most recently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_r <= OWN_FETCH;
        end else if (gnt_d_s) begin
            last_owner_r <= OWN_DATA;
        end else if (gnt_i_s) begin
            last_owner_r <= OWN_FETCH;
        end
    end
`else
    // Data port always wins a tie.
    always_comb begin
        pick_data_s = bus.d_req;
    end
`endif

    assign any_gnt_s = gnt_d_s | gnt_i_s;

    // Fetch is presented to the formatter as an aligned word read.
    assign req_addr_s   = gnt_d_s ? bus.d_addr : bus.if_addr;
    assign st_size_s    = gnt_d_s ? bus.d_size : MEM_SIZE_W;
    assign st_addr_lo_s = gnt_d_s ? req_addr_s[1:0] : 2'b00;
    assign st_we_s      = gnt_d_s & bus.d_we;

    mem_lane_fmt u_lane_fmt (
        .st_size       (st_size_s),
        .st_addr_lo    (st_addr_lo_s),
        .st_we         (st_we_s),
        .st_wdata      (bus.d_wdata),
        .st_mask       (st_mask_s),
        .st_lane_wdata (st_lane_wdata_s),
        .st_err        (st_err_s),
        .ld_size       (size_r),
        .ld_addr_lo    (addr_lo_r),
        .ld_unsigned   (unsigned_r),
        .ld_rdata      (bus.mem_rdata),
        .ld_data       (ld_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= MEM_ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MEM_ARB_IDLE:  state_next_s = any_gnt_s ? MEM_ARB_ISSUE : MEM_ARB_IDLE;
            MEM_ARB_ISSUE: state_next_s = MEM_ARB_RESP;
            MEM_ARB_RESP:  state_next_s = any_gnt_s ? MEM_ARB_ISSUE : MEM_ARB_IDLE;
            default:       state_next_s = MEM_ARB_IDLE;
        endcase
    end

    // FSM outputs: grants and the response for the current owner; reset forces grants low.
    always_comb begin
        grant_ok_s  = 1'b0;
        if_rvalid_s = 1'b0;
        if_rdata_s  = {API_DATA_WIDTH{1'b0}};
        d_rvalid_s  = 1'b0;
        d_rdata_s   = {API_DATA_WIDTH{1'b0}};
        d_err_s     = 1'b0;
        case (state_r)
            MEM_ARB_IDLE:  grant_ok_s = 1'b1;
            MEM_ARB_ISSUE: grant_ok_s = 1'b0;
            MEM_ARB_RESP: begin
                grant_ok_s = 1'b1;
                if (owner_r == OWN_FETCH) begin
                    if_rvalid_s = 1'b1;
                    if_rdata_s  = bus.mem_rdata;
                end else begin
                    d_rvalid_s = 1'b1;
                    d_err_s    = err_r;
                    d_rdata_s  = (we_r || err_r) ? {API_DATA_WIDTH{1'b0}} : ld_data_s;
                end
            end
            default: grant_ok_s = 1'b0;
        endcase
        gnt_d_s = grant_ok_s & reset_n & pick_data_s;
        gnt_i_s = grant_ok_s & reset_n & bus.if_req & ~pick_data_s;
    end

    // Latch the access at grant; RAM strobes live for exactly the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r       <= OWN_FETCH;
            size_r        <= 2'b00;
            addr_lo_r     <= 2'b00;
            we_r          <= 1'b0;
            unsigned_r    <= 1'b0;
            err_r         <= 1'b0;
            mem_en_r      <= 1'b0;
            mem_addr_r    <= {API_ADDR_WIDTH{1'b0}};
            mem_wdata_r   <= {API_DATA_WIDTH{1'b0}};
            mem_wr_mask_r <= 4'b0000;
        end else if (any_gnt_s) begin
            owner_r       <= gnt_d_s ? OWN_DATA : OWN_FETCH;
            size_r        <= st_size_s;
            addr_lo_r     <= st_addr_lo_s;
            we_r          <= st_we_s;
            unsigned_r    <= gnt_d_s & bus.d_unsigned;
            err_r         <= st_err_s;
            mem_en_r      <= ~st_err_s;
            mem_addr_r    <= st_err_s ? {API_ADDR_WIDTH{1'b0}} : {req_addr_s[API_ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_r   <= st_lane_wdata_s;
            mem_wr_mask_r <= st_mask_s;
        end else begin
            mem_en_r      <= 1'b0;
            mem_addr_r    <= {API_ADDR_WIDTH{1'b0}};
            mem_wdata_r   <= {API_DATA_WIDTH{1'b0}};
            mem_wr_mask_r <= 4'b0000;
        end
    end

    assign bus.if_gnt      = gnt_i_s;
    assign bus.if_rvalid   = if_rvalid_s;
    assign bus.if_rdata    = if_rdata_s;
    assign bus.d_gnt       = gnt_d_s;
    assign bus.d_rvalid    = d_rvalid_s;
    assign bus.d_rdata     = d_rdata_s;
    assign bus.d_err       = d_err_s;
    assign bus.mem_en      = mem_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.mem_wr_mask = mem_wr_mask_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word RAM model behind it.
// Build with MEM_ARB_RR_EN defined to expect round-robin grants.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [31:0] ram [0:255];

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // RAM: masked write and registered read, one cycle after mem_en.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wr_mask[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr[9:2]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required $finish before 200000");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one data access from IDLE and checks T, T+1, T+2 and the return to IDLE.
    task automatic d_access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err,
                            input logic [3:0] exp_mask, input logic [31:0] exp_mwdata,
                            input logic [31:0] exp_rdata);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_unsigned = uns;
        bus.d_addr = addr; bus.d_wdata = wdata;
        #1;
        check_eq({tag, ".gnt"}, bus.d_gnt, 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = ~we; bus.d_size = 2'b11; bus.d_unsigned = ~uns;
        bus.d_addr = 32'hFFFF_FFFF; bus.d_wdata = 32'hDEAD_BEEF;
        check_eq({tag, ".mem_en"}, bus.mem_en, {31'd0, ~exp_err});
        if (!exp_err) begin
            check_eq({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            check_eq({tag, ".mask"}, bus.mem_wr_mask, exp_mask);
        end
        if (we && !exp_err) check_eq({tag, ".mem_wdata"}, bus.mem_wdata, exp_mwdata);
        @(posedge clk); #1;
        check_eq({tag, ".rvalid"}, bus.d_rvalid, 32'd1);
        check_eq({tag, ".err"}, bus.d_err, exp_err);
        check_eq({tag, ".rdata"}, bus.d_rdata, exp_rdata);
        check_eq({tag, ".mem_en_t2"}, bus.mem_en, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, ".rvalid_idle"}, bus.d_rvalid, 32'd0);
        check_eq({tag, ".rdata_idle"}, bus.d_rdata, 32'd0);
    endtask

    // Runs one fetch from IDLE.
    task automatic f_access(input string tag, input logic [31:0] addr, input logic [31:0] exp_rdata);
        bus.if_req = 1'b1; bus.if_addr = addr;
        #1;
        check_eq({tag, ".gnt"}, bus.if_gnt, 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.if_addr = 32'hFFFF_FFFF;
        check_eq({tag, ".mem_en"}, bus.mem_en, 32'd1);
        check_eq({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        check_eq({tag, ".mask"}, bus.mem_wr_mask, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, ".rvalid"}, bus.if_rvalid, 32'd1);
        check_eq({tag, ".rdata"}, bus.if_rdata, exp_rdata);
        check_eq({tag, ".d_rvalid"}, bus.d_rvalid, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, ".rvalid_idle"}, bus.if_rvalid, 32'd0);
        check_eq({tag, ".rdata_idle"}, bus.if_rdata, 32'd0);
    endtask

    initial begin
        logic exp_d, exp_i;
        reset_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_size = 2'b00; bus.d_unsigned = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        bus.d_req = 1'b1; bus.if_req = 1'b1;
        #1;
        check_eq("rst.d_gnt", bus.d_gnt, 32'd0);
        check_eq("rst.if_gnt", bus.if_gnt, 32'd0);
        check_eq("rst.mem_en", bus.mem_en, 32'd0);
        check_eq("rst.mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst.mem_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst.mask", bus.mem_wr_mask, 32'd0);
        check_eq("rst.d_rvalid", bus.d_rvalid, 32'd0);
        check_eq("rst.if_rvalid", bus.if_rvalid, 32'd0);
        check_eq("rst.d_err", bus.d_err, 32'd0);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Preload RAM through the arbiter, then the lane/extension cases.
        d_access("st_w100", 1'b1, MEM_SIZE_W, 1'b0, 32'h100, 32'h80FF_1234, 1'b0, 4'b1111, 32'h80FF_1234, 32'h0);
        d_access("st_w200", 1'b1, MEM_SIZE_W, 1'b0, 32'h200, 32'h1111_2222, 1'b0, 4'b1111, 32'h1111_2222, 32'h0);
        d_access("ld_b103s", 1'b0, MEM_SIZE_B, 1'b0, 32'h103, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        d_access("ld_b103u", 1'b0, MEM_SIZE_B, 1'b1, 32'h103, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_0080);
        d_access("ld_b100s", 1'b0, MEM_SIZE_B, 1'b0, 32'h100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_0034);
        d_access("ld_b102s", 1'b0, MEM_SIZE_B, 1'b0, 32'h102, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FFFF);
        d_access("ld_h102s", 1'b0, MEM_SIZE_H, 1'b0, 32'h102, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_80FF);
        d_access("ld_h100u", 1'b0, MEM_SIZE_H, 1'b1, 32'h100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_1234);
        d_access("ld_w100", 1'b0, MEM_SIZE_W, 1'b0, 32'h100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h80FF_1234);
        d_access("st_h202", 1'b1, MEM_SIZE_H, 1'b0, 32'h202, 32'h5555_ABCD, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        d_access("err_st_h203", 1'b1, MEM_SIZE_H, 1'b0, 32'h203, 32'h0000_FFFF, 1'b1, 4'b0000, 32'h0, 32'h0);
        f_access("f_200", 32'h200, 32'hABCD_2222);
        d_access("err_ld_w101", 1'b0, MEM_SIZE_W, 1'b0, 32'h101, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        d_access("err_ld_rsv", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);

        // Reset asserted in the ISSUE cycle of a fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        check_eq("rmid.if_gnt", bus.if_gnt, 32'd1);
        @(posedge clk); #1;
        check_eq("rmid.mem_en_issue", bus.mem_en, 32'd1);
        bus.if_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = MEM_SIZE_B; bus.d_addr = 32'h301;
        reset_n = 1'b0;
        #1;
        check_eq("rmid.mem_en", bus.mem_en, 32'd0);
        check_eq("rmid.mem_addr", bus.mem_addr, 32'd0);
        check_eq("rmid.d_gnt", bus.d_gnt, 32'd0);
        @(posedge clk); #1;
        check_eq("rmid.if_rvalid", bus.if_rvalid, 32'd0);
        bus.d_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rmid.if_rvalid_after", bus.if_rvalid, 32'd0);
        d_access("post_rst_st_b301", 1'b1, MEM_SIZE_B, 1'b0, 32'h301, 32'h7777_775A, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0);

        // Back-to-back store then load of the same word.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = MEM_SIZE_W; bus.d_unsigned = 1'b0;
        bus.d_addr = 32'h300; bus.d_wdata = 32'h1234_5678;
        #1;
        check_eq("b2b.st_gnt", bus.d_gnt, 32'd1);
        @(posedge clk); #1;
        bus.d_we = 1'b0; bus.d_wdata = 32'h0;
        check_eq("b2b.st_mem_en", bus.mem_en, 32'd1);
        check_eq("b2b.st_mask", bus.mem_wr_mask, 32'hF);
        #1;
        check_eq("b2b.issue_gnt", bus.d_gnt, 32'd0);
        @(posedge clk); #1;
        check_eq("b2b.st_rvalid", bus.d_rvalid, 32'd1);
        check_eq("b2b.st_rdata", bus.d_rdata, 32'd0);
        check_eq("b2b.mem_en_t2", bus.mem_en, 32'd0);
        check_eq("b2b.ld_gnt", bus.d_gnt, 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        check_eq("b2b.ld_mem_en", bus.mem_en, 32'd1);
        check_eq("b2b.ld_mask", bus.mem_wr_mask, 32'd0);
        check_eq("b2b.ld_addr", bus.mem_addr, 32'h300);
        @(posedge clk); #1;
        check_eq("b2b.ld_rvalid", bus.d_rvalid, 32'd1);
        check_eq("b2b.ld_rdata", bus.d_rdata, 32'h1234_5678);
        @(posedge clk); #1;

        // Both ports requesting continuously, starting from a fresh reset.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = MEM_SIZE_W; bus.d_addr = 32'h100;
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_d = (k % 2 == 0) && (!RR || (k % 4 == 0));
            exp_i = (k % 2 == 0) && RR && (k % 4 == 2);
            check_eq($sformatf("prio%0d.d_gnt", k), bus.d_gnt, {31'd0, exp_d});
            check_eq($sformatf("prio%0d.if_gnt", k), bus.if_gnt, {31'd0, exp_i});
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
